mem_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one Main_memory256 port between two cache controllers.

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing a single memory port between two cache controllers.
// Serialises accesses, returns data/done per port and broadcasts write snoop-invalidates.
module mem_bus_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req1,
  input  logic          req2,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic          gnt1,
  output logic          gnt2,
  output logic          done1,
  output logic          done2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          err1,
  output logic          err2,
  output logic          inv1,
  output logic          inv2,
  output logic [AW-1:0] inv_addr1,
  output logic [AW-1:0] inv_addr2,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rd_done,
  input  logic          mem_wr_done
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 0 = port 1, 1 = port 2
  logic          last_q, last_d;     // port that was served most recently
  logic          we_q, we_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          gnt1_d, gnt2_d, done1_d, done2_d, err1_d, err2_d, inv1_d, inv2_d;
  logic [DW-1:0] rdata1_d, rdata2_d, mem_wdata_d;
  logic [AW-1:0] inv_addr1_d, inv_addr2_d, mem_addr_d;
  logic          mem_rd_en_d, mem_wr_en_d;
  logic          pick2, hit;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      timer_q   <= '0;
      gnt1      <= 1'b0;
      gnt2      <= 1'b0;
      done1     <= 1'b0;
      done2     <= 1'b0;
      err1      <= 1'b0;
      err2      <= 1'b0;
      inv1      <= 1'b0;
      inv2      <= 1'b0;
      rdata1    <= '0;
      rdata2    <= '0;
      inv_addr1 <= '0;
      inv_addr2 <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      timer_q   <= timer_d;
      gnt1      <= gnt1_d;
      gnt2      <= gnt2_d;
      done1     <= done1_d;
      done2     <= done2_d;
      err1      <= err1_d;
      err2      <= err2_d;
      inv1      <= inv1_d;
      inv2      <= inv2_d;
      rdata1    <= rdata1_d;
      rdata2    <= rdata2_d;
      inv_addr1 <= inv_addr1_d;
      inv_addr2 <= inv_addr2_d;
      mem_rd_en <= mem_rd_en_d;
      mem_wr_en <= mem_wr_en_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    timer_d     = timer_q;
    gnt1_d      = gnt1;
    gnt2_d      = gnt2;
    done1_d     = 1'b0;
    done2_d     = 1'b0;
    err1_d      = 1'b0;
    err2_d      = 1'b0;
    inv1_d      = 1'b0;
    inv2_d      = 1'b0;
    rdata1_d    = rdata1;
    rdata2_d    = rdata2;
    inv_addr1_d = inv_addr1;
    inv_addr2_d = inv_addr2;
    mem_rd_en_d = mem_rd_en;
    mem_wr_en_d = mem_wr_en;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    pick2       = 1'b0;
    hit         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          // Under contention the port not served last time wins
          pick2       = req2 && (!req1 || !last_q);
          owner_d     = pick2;
          we_d        = pick2 ? we2 : we1;
          mem_addr_d  = pick2 ? addr2 : addr1;
          mem_wdata_d = pick2 ? wdata2 : wdata1;
          mem_rd_en_d = !we_d;
          mem_wr_en_d = we_d;
          gnt1_d      = !pick2;
          gnt2_d      = pick2;
          timer_d     = '0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        hit = we_q ? mem_wr_done : mem_rd_done;
        if (hit) begin
          state_d     = RESP;
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          done1_d     = !owner_q;
          done2_d     = owner_q;
          if (!we_q) begin
            if (owner_q) rdata2_d = mem_rdata;
            else         rdata1_d = mem_rdata;
          end else if (owner_q) begin
            inv1_d      = 1'b1;
            inv_addr1_d = mem_addr;
          end else begin
            inv2_d      = 1'b1;
            inv_addr2_d = mem_addr;
          end
        end else if (timer_q == TLAST) begin
          state_d     = RESP;
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          err1_d      = !owner_q;
          err2_d      = owner_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      RESP: begin
        gnt1_d  = 1'b0;
        gnt2_d  = 1'b0;
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req1, req2, we1, we2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] wdata1, wdata2;
  logic          gnt1, gnt2, done1, done2, err1, err2, inv1, inv2;
  logic [DW-1:0] rdata1, rdata2;
  logic [AW-1:0] inv_addr1, inv_addr2, mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd_en, mem_wr_en, mem_rd_done, mem_wr_done;

  logic resp_rd, resp_wr, stray_rd, stray_wr, mute;
  int   lat, cnt;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;
  int   order[$];

  assign mem_rd_done = resp_rd | stray_rd;
  assign mem_wr_done = resp_wr | stray_wr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
    .gnt1(gnt1), .gnt2(gnt2), .done1(done1), .done2(done2),
    .rdata1(rdata1), .rdata2(rdata2), .err1(err1), .err2(err2),
    .inv1(inv1), .inv2(inv2), .inv_addr1(inv_addr1), .inv_addr2(inv_addr2),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the bus, how long it has waited, and whether it is answering
  int          m_owner, m_last, m_age;
  logic        m_we, m_fin, m_err, m_inv1, m_inv2;
  logic [7:0]  m_addr, m_wdata, m_rdata1, m_rdata2, m_inva1, m_inva2;

  function automatic int pick(input logic r1, input logic r2, input int last);
    return (r1 && (!r2 || last == 2)) ? 1 : 2;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner <= 0; m_last <= 2; m_age <= 0; m_we <= 1'b0; m_fin <= 1'b0; m_err <= 1'b0;
      m_inv1 <= 1'b0; m_inv2 <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata1 <= '0; m_rdata2 <= '0; m_inva1 <= '0; m_inva2 <= '0;
    end else begin
      m_inv1 <= 1'b0;
      m_inv2 <= 1'b0;
      if (m_fin) begin
        m_last <= m_owner; m_owner <= 0; m_fin <= 1'b0; m_err <= 1'b0;
      end else if (m_owner != 0) begin
        if (m_we ? mem_wr_done : mem_rd_done) begin
          m_fin <= 1'b1;
          if (!m_we) begin
            if (m_owner == 1) m_rdata1 <= mem_rdata; else m_rdata2 <= mem_rdata;
          end else if (m_owner == 1) begin
            m_inv2 <= 1'b1; m_inva2 <= m_addr;
          end else begin
            m_inv1 <= 1'b1; m_inva1 <= m_addr;
          end
        end else if (m_age == int'(TO) - 1) begin
          m_fin <= 1'b1; m_err <= 1'b1;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (req1 || req2) begin
        m_owner <= pick(req1, req2, m_last);
        m_age   <= 0;
        m_we    <= (pick(req1, req2, m_last) == 1) ? we1 : we2;
        m_addr  <= (pick(req1, req2, m_last) == 1) ? addr1 : addr2;
        m_wdata <= (pick(req1, req2, m_last) == 1) ? wdata1 : wdata2;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt1", 64'(gnt1), 64'(m_owner == 1));
      chk("gnt2", 64'(gnt2), 64'(m_owner == 2));
      chk("gnt_excl", 64'(gnt1 && gnt2), 64'(0));
      chk("done1", 64'(done1), 64'(m_fin && !m_err && m_owner == 1));
      chk("done2", 64'(done2), 64'(m_fin && !m_err && m_owner == 2));
      chk("err1", 64'(err1), 64'(m_fin && m_err && m_owner == 1));
      chk("err2", 64'(err2), 64'(m_fin && m_err && m_owner == 2));
      chk("inv1", 64'(inv1), 64'(m_inv1));
      chk("inv2", 64'(inv2), 64'(m_inv2));
      chk("inv_addr1", 64'(inv_addr1), 64'(m_inva1));
      chk("inv_addr2", 64'(inv_addr2), 64'(m_inva2));
      chk("rdata1", 64'(rdata1), 64'(m_rdata1));
      chk("rdata2", 64'(rdata2), 64'(m_rdata2));
      chk("mem_rd_en", 64'(mem_rd_en), 64'(m_owner != 0 && !m_fin && !m_we));
      chk("mem_wr_en", 64'(mem_wr_en), 64'(m_owner != 0 && !m_fin && m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
  end

  // Memory responder: done pulse after lat enabled cycles unless muted
  initial begin
    resp_rd = 1'b0; resp_wr = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      resp_rd = 1'b0; resp_wr = 1'b0;
      if ((mem_rd_en || mem_wr_en) && !mute) begin
        cnt++;
        if (cnt == lat) begin resp_rd = mem_rd_en; resp_wr = mem_wr_en; end
      end else begin
        cnt = 0;
      end
    end
  end

  // Caller is 1ns after a rising edge; returns 1 on done, 2 on err, 0 on expired bound
  task automatic do_req(input int p, input logic we, input logic [7:0] a, input logic [7:0] d,
                        input bit drop, output int fin);
    fin = 0;
    if (p == 1) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else        begin req2 = 1'b1; we2 = we; addr2 = a; wdata2 = d; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (p == 1 && (done1 || err1)) begin fin = done1 ? 1 : 2; break; end
      if (p == 2 && (done2 || err2)) begin fin = done2 ? 1 : 2; break; end
    end
    if (fin == 0) chk($sformatf("port%0d_timeout", p), 64'(0), 64'(1));
    if (fin == 1) order.push_back(p);
    if (drop) begin
      @(posedge clk); #1;
      if (p == 1) req1 = 1'b0; else req2 = 1'b0;
    end
  endtask

  task automatic cycle_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int fa, fb, k, en_cnt, bad_pulse;

  initial begin
    rst = 1'b1;
    req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    addr1 = '0; addr2 = '0; wdata1 = '0; wdata2 = '0;
    mem_rdata = '0; stray_rd = 1'b0; stray_wr = 1'b0; mute = 1'b0; lat = 1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {gnt1, gnt2, done1, done2, err1, err2, inv1, inv2, mem_rd_en, mem_wr_en,
                          rdata1, rdata2, inv_addr1, inv_addr2, mem_addr, mem_wdata}, 64'(0));
    chk_on = 1'b1;
    rst = 1'b1;

    // 1: read from port 1, memory answers after 4 cycles
    lat = 4; mem_rdata = 8'hA5;
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h00;
    @(posedge clk); #1;
    chk("t1_gnt1", 64'(gnt1), 64'(1));
    chk("t1_mem_addr", 64'(mem_addr), 64'h10);
    k = 0;
    while (!done1 && k < 50) begin @(negedge clk); k++; end
    chk("t1_done_latency", 64'(k), 64'(5));
    chk("t1_rdata1", 64'(rdata1), 64'hA5);
    chk("t1_no_inv", 64'({inv1, inv2}), 64'(0));
    @(posedge clk); #1 req1 = 1'b0;

    // 2: write from port 2 invalidates port 1
    lat = 2;
    req2 = 1'b1; we2 = 1'b1; addr2 = 8'h22; wdata2 = 8'h5C;
    @(posedge clk); #1;
    chk("t2_wr_en", 64'({mem_wr_en, mem_rd_en, gnt2}), 64'b101);
    chk("t2_mem_addr", 64'(mem_addr), 64'h22);
    chk("t2_mem_wdata", 64'(mem_wdata), 64'h5C);
    k = 0;
    while (!done2 && k < 50) begin @(negedge clk); k++; end
    chk("t2_done2", 64'(done2), 64'(1));
    chk("t2_inv1", 64'({inv1, inv2}), 64'b10);
    chk("t2_inv_addr1", 64'(inv_addr1), 64'h22);
    @(posedge clk); #1 req2 = 1'b0;

    // Stray read-done in IDLE must change nothing
    stray_rd = 1'b1;
    @(posedge clk); #1 stray_rd = 1'b0;

    // 3: simultaneous held requests after reset alternate 1,2,1,2
    cycle_reset();
    lat = 1;
    order.delete();
    fork
      begin
        do_req(1, 1'b0, 8'h31, 8'h00, 1'b0, fa);
        do_req(1, 1'b1, 8'h32, 8'h77, 1'b1, fa);
      end
      begin
        do_req(2, 1'b1, 8'h41, 8'h11, 1'b0, fb);
        do_req(2, 1'b0, 8'h42, 8'h00, 1'b1, fb);
      end
    join
    chk("t3_count", 64'(order.size()), 64'(4));
    if (order.size() == 4)
      chk("t3_order", {32'(order[0]), 8'(order[1]), 8'(order[2]), 16'(order[3])},
          {32'(1), 8'(2), 8'(1), 16'(2)});

    // 4: memory never answers, timeout error after TO enabled cycles
    mute = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h44;
    en_cnt = 0;
    for (int i = 0; i < int'(TO) + 20; i++) begin
      @(negedge clk);
      if (mem_rd_en) en_cnt++;
      if (err1 || done1) break;
    end
    chk("t4_en_cycles", 64'(en_cnt), 64'(TO));
    chk("t4_err_not_done", 64'({err1, done1}), 64'b10);
    @(posedge clk); #1 req1 = 1'b0; mute = 1'b0;
    @(negedge clk);
    chk("t4_bus_idle", 64'({gnt1, gnt2, mem_rd_en}), 64'(0));

    // 5: reset during ACCESS of a write
    @(posedge clk); #1;
    mute = 1'b1;
    req2 = 1'b1; we2 = 1'b1; addr2 = 8'h55; wdata2 = 8'h66;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t5_async_zero", {gnt1, gnt2, done1, done2, err1, err2, inv1, inv2, mem_rd_en, mem_wr_en,
                          rdata1, rdata2, inv_addr1, inv_addr2, mem_addr, mem_wdata}, 64'(0));
    req2 = 1'b0; mute = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    bad_pulse = 0;
    repeat (4) begin
      @(negedge clk);
      if (done1 || done2 || inv1 || inv2 || gnt1 || gnt2) bad_pulse++;
    end
    chk("t5_quiet_after_reset", 64'(bad_pulse), 64'(0));
    @(posedge clk); #1;
    lat = 1; mem_rdata = 8'h3C;
    do_req(1, 1'b0, 8'h77, 8'h00, 1'b1, fa);
    chk("t5_new_req_done", 64'(fa), 64'(1));
    chk("t5_rdata1", 64'(rdata1), 64'h3C);

    // 6: stray write-done during a read is ignored
    lat = 3; mem_rdata = 8'h9E;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h88;
    @(posedge clk); #1;
    stray_wr = 1'b1;
    @(posedge clk); #1 stray_wr = 1'b0;
    chk("t6_still_access", 64'({gnt1, done1, mem_rd_en}), 64'b101);
    k = 0;
    while (!done1 && k < 50) begin @(negedge clk); k++; end
    chk("t6_done1", 64'(done1), 64'(1));
    chk("t6_rdata1", 64'(rdata1), 64'h9E);
    @(posedge clk); #1 req1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
